priority_encoder: RTL and testbench
===================================

// Module: priority_encoder
// PURPOSE
//   Registered N-to-log2(N) priority encoder, highest index wins.
//   Reports the index of the most-significant asserted request bit on d, with a valid flag.
//   Used as a request arbiter/index generator ahead of muxing or interrupt logic.
//   Single clock domain; output is registered (1-cycle latency).
// PARAMETERS
//   N   8             number of request inputs (>=2, power of two)
//   W   $clog2(N)=3   localparam, output index width
// PORTS
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   d       in   N   request vector; bit i = request i
//   en      in   1   encoder enable; 0 forces idle output
//   y       out  W   encoded index of highest set bit of d
//   valid   out  1   1 when en=1 and d!=0 (y meaningful)
// BEHAVIOUR
//   - Reset: rst_n=0 asynchronously drives y=0, valid=0; held until rst_n released.
//     First update happens on the first rising clk edge after release.
//   - Each rising clk edge, with rst_n=1:
//       en=1, d!=0 : y <= max i such that d[i]=1 ; valid <= 1
//       en=1, d==0 : y <= 0 ; valid <= 0
//       en=0       : y <= 0 ; valid <= 0 (d ignored)
//   - Latency: exactly 1 cycle from d/en sampled to y/valid; no handshake, no back-pressure.
//     A new result appears every cycle.
//   - Priority is absolute, MSB highest: lower bits are don't-care once a higher bit is set.
//     Example: 8'b11001001 -> 7; 8'b00110001 -> 5; 8'b00000001 -> 0.
//   - d==0 and d==1 both give y=0; valid distinguishes them.
//   - en toggling mid-stream takes effect on the next edge only; no state beyond the output registers.
//   - Inputs are synchronous to clk; no internal synchronizers.
//   - X on d with en=1 is not required to be handled.
// CONFIGURATION
//   Macro PRI_EN_ONEHOT_EN:
//     defined     -> extra output port onehot [N-1:0], registered with y.
//                    onehot = 1<<y when valid=1, else 0. Reset value is 0.
//     not defined -> port absent; y/valid behaviour unchanged.
// STRUCTURE
//   - Shared package pri_enc_pkg:
//       localparam PRI_N_DEFAULT=8
//       function automatic msb_index(input logic [N-1:0] v), returning the W-bit index of the highest set bit.
//   - Sub-module pri_enc_core: purely combinational.
//       Inputs d, en; outputs next_y, next_valid (and next_onehot when the macro is defined).
//       The top module instantiates it and owns the async-reset output registers.
// TESTING
//   1. Reset: assert rst_n=0 mid-run with d=8'hFF, en=1 -> y=0, valid=0 immediately, without waiting for clk.
//   2. Single bits: en=1, d=1<<i for i=0..7 -> y=i, valid=1 one cycle later.
//   3. Priority: d=8'b00000011->1, 8'b00000101->2, 8'b00001001->3, 8'b01110001->6,
//      8'b10111001->7, 8'b00101010->5, 8'b10100010->7.
//   4. Empty: en=1, d=0 -> y=0, valid=0. Then d=8'b00000001 -> y=0, valid=1.
//   5. Enable: en=0, d=8'b11001001 -> y=0, valid=0. Raise en=1 -> y=7, valid=1 on the next edge.
//   6. With PRI_EN_ONEHOT_EN: d=8'b00101010, en=1 -> onehot=8'b00100000. Then d=0 -> onehot=0.
//   Bench compares against a reference model delayed by one cycle, over 1000 random d/en vectors.

Source files
------------

// File: rtl/pri_enc_pkg.sv
// Shared definitions for the registered priority encoder.
// Provides the default request width and the MSB-index helper used by the core.
package pri_enc_pkg;

  localparam int PRI_N_DEFAULT = 8;
  localparam int PRI_W_DEFAULT = $clog2(PRI_N_DEFAULT);

  // Highest set bit wins; an all-zero vector returns 0 and is disambiguated by valid.
  function automatic logic [PRI_W_DEFAULT-1:0] msb_index(input logic [PRI_N_DEFAULT-1:0] v);
    logic [PRI_W_DEFAULT-1:0] idx;
    idx = '0;
    for (int i = 0; i < PRI_N_DEFAULT; i++) begin
      if (v[i]) idx = i[PRI_W_DEFAULT-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/pri_enc_core.sv
// Combinational next-state logic for priority_encoder: MSB-first index, valid, and optional one-hot.
// The one-hot output exists only when PRI_EN_ONEHOT_EN is defined.
module pri_enc_core
  import pri_enc_pkg::*;
#(
  parameter int N = PRI_N_DEFAULT,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] d,
  input  logic         en,
`ifdef PRI_EN_ONEHOT_EN
  output logic [N-1:0] next_onehot,
`endif
  output logic [W-1:0] next_y,
  output logic         next_valid
);

  logic [W-1:0] raw_idx;
  logic         any_req;

  assign any_req = |d;

  generate
    if (N == PRI_N_DEFAULT) begin : g_pkg_idx
      assign raw_idx = msb_index(d);
    end else begin : g_loop_idx
      always_comb begin
        raw_idx = '0;
        for (int i = 0; i < N; i++) begin
          if (d[i]) raw_idx = i[W-1:0];
        end
      end
    end
  endgenerate

  // Disabled or empty requests both present as an idle index of 0.
  always_comb begin
    next_valid = en & any_req;
    next_y     = next_valid ? raw_idx : '0;
  end

`ifdef PRI_EN_ONEHOT_EN
  always_comb begin
    next_onehot = '0;
    if (next_valid) next_onehot[next_y] = 1'b1;
  end
`endif

endmodule

// File: rtl/priority_encoder.sv
// Registered N-to-log2(N) priority encoder, highest index wins, one cycle latency.
// Define PRI_EN_ONEHOT_EN to add a registered one-hot copy of the winning index.
module priority_encoder
  import pri_enc_pkg::*;
#(
  parameter int N = PRI_N_DEFAULT,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  input  logic         en,
`ifdef PRI_EN_ONEHOT_EN
  output logic [N-1:0] onehot,
`endif
  output logic [W-1:0] y,
  output logic         valid
);

  logic [W-1:0] next_y;
  logic         next_valid;

`ifdef PRI_EN_ONEHOT_EN
  logic [N-1:0] next_onehot;
`endif

  pri_enc_core #(.N(N)) u_core (
    .d          (d),
    .en         (en),
`ifdef PRI_EN_ONEHOT_EN
    .next_onehot(next_onehot),
`endif
    .next_y     (next_y),
    .next_valid (next_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
    end else begin
      y     <= next_y;
      valid <= next_valid;
    end
  end

`ifdef PRI_EN_ONEHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) onehot <= '0;
    else        onehot <= next_onehot;
  end
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder using a one-cycle-delayed scoreboard model.
// Covers reset, single bits, priority patterns, empty/enable cases and random vectors.
module tb_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;

  typedef struct packed {
    logic [W-1:0] y;
    logic         valid;
    logic [N-1:0] onehot;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] d;
  logic         en;
  logic [W-1:0] y;
  logic         valid;
  logic [N-1:0] onehot_obs;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  priority_encoder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .en    (en),
`ifdef PRI_EN_ONEHOT_EN
    .onehot(onehot_obs),
`endif
    .y     (y),
    .valid (valid)
  );

`ifndef PRI_EN_ONEHOT_EN
  assign onehot_obs = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model scans from the MSB down, independent of the RTL loop direction.
  function automatic exp_t model(input logic [N-1:0] v, input logic e);
    exp_t r;
    r = '0;
    if (e && v != '0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (v[i]) begin
          r.y = i[W-1:0];
          break;
        end
      end
      r.valid  = 1'b1;
      r.onehot = '0;
      r.onehot[r.y] = 1'b1;
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check_val({tag, ".y"}, 32'(y), 32'(e.y));
    check_val({tag, ".valid"}, 32'(valid), 32'(e.valid));
`ifdef PRI_EN_ONEHOT_EN
    check_val({tag, ".onehot"}, 32'(onehot_obs), 32'(e.onehot));
`endif
  endtask

  // Drive one vector, push its expectation, then compare after the sampling edge.
  task automatic step(input string tag, input logic [N-1:0] dv, input logic ev);
    exp_t e;
    d  = dv;
    en = ev;
    sb.push_back(model(dv, ev));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, sb.size());
    end else begin
      e = sb.pop_front();
      check_out(tag, e);
    end
  endtask

  initial begin
    logic [N-1:0] pat [7];
    exp_t zero_e;
    zero_e = '0;
    pat = '{8'b00000011, 8'b00000101, 8'b00001001, 8'b01110001,
            8'b10111001, 8'b00101010, 8'b10100010};

    rst_n = 1'b0;
    d     = '0;
    en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_hold", zero_e);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) step("single_bit", 8'(1 << i), 1'b1);
    for (int i = 0; i < 7; i++) step("priority", pat[i], 1'b1);

    step("empty", 8'h00, 1'b1);
    step("bit0_valid", 8'h01, 1'b1);

    step("en_low", 8'b11001001, 1'b0);
    step("en_high", 8'b11001001, 1'b1);

    step("onehot_mid", 8'b00101010, 1'b1);
    step("onehot_zero", 8'h00, 1'b1);

    // Asynchronous reset mid-run with active requests pending.
    step("pre_reset", 8'hFF, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", zero_e);
    @(posedge clk);
    #1;
    check_out("reset_edge", zero_e);
    rst_n = 1'b1;
    step("post_reset", 8'hFF, 1'b1);

    for (int k = 0; k < 1000; k++) begin
      step("random", 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
